// File: rtl/rv_pkg.sv
// Shared fetch-side types and constants.
// No logic; types only.
// No flow control.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    // One decoded-stage-bound entry: instruction word plus its address.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshakes.
// No logic; wiring only.
// master = fetch unit, slave = memory/decoder/branch environment.
interface fetch_unit_if;
    import rv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer with the head read straight from storage flops.
// Push visible at head the cycle after it is written.
// No internal backpressure: caller must never push while full; flush wins.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage, pointers and occupancy; flush drops every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{instr: INSTR_NOP, pc: '0};
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited memory requests, buffered delivery to decode.
// Response reaches decode 1 cycle after it arrives; request goes out combinationally.
// Requests stall on missing credit or redirect; decode stalls via if_ready.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] tag_q [FIFO_DEPTH];
    logic [AW-1:0]   tag_wr;
    logic [AW-1:0]   tag_rd;
    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    // Dropped-but-still-in-flight requests keep consuming credit until they return.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
    assign bus.imem_req_addr  = pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    // A redirect discards the response of its own cycle and ignores the decoder pop.
    assign push = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
    assign pop  = bus.if_valid && bus.if_ready && !bus.redirect_valid;

    assign push_data = '{instr: bus.imem_rsp_data, pc: tag_q[tag_rd]};

    assign bus.if_valid = !fifo_empty;
    assign bus.if_instr = head.instr;
    assign bus.if_pc    = head.pc;

    // PC and the request-order address tags that label returning words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            tag_wr <= '0;
            tag_rd <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            pc     <= bus.redirect_pc & ~XLEN'(3);
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (req_fire) begin
                pc            <= pc + PC_STEP;
                tag_q[tag_wr] <= pc;
                tag_wr        <= tag_wr + AW'(1);
            end
            if (push) begin
                tag_rd <= tag_rd + AW'(1);
            end
        end
    end

    // In-flight request count and how many of them belong to a flushed stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.redirect_valid) begin
                drop_cnt <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rsp_valid && (outstanding == '0)));
    a_drop_bound: assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    int errors = 0;
    int checks = 0;
    int cyc;
    int lat_min, lat_max, last_due;
    int dropped;
    int first_valid_cyc;
    int max_occ;
    req_t        mem_q[$];
    ent_t        exp_q[$];
    logic [31:0] deliv_q[$];
    logic [31:0] accept_q[$];
    logic [31:0] model_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b1;
        mem_q.delete();
        exp_q.delete();
        deliv_q.delete();
        accept_q.delete();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_instr", bus.if_instr, INSTR_NOP);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;
        last_due = 0;
        model_pc = 32'h0;
        lat_min = 1;
        lat_max = 1;
        dropped = 0;
        first_valid_cyc = 0;
        max_occ = 0;
    endtask

    // One clock cycle: memory model drives its response, outputs are checked
    // against the reference queues, then the reference state advances.
    task automatic tick();
        bit rsp, hs, pop, redir;
        int lat, due;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? (mem_q[0].addr ^ KEY) : 32'h0;
        redir = bus.redirect_valid;
        #1;
        chk("req_valid", 32'(bus.imem_req_valid),
            32'(!redir && (mem_q.size() + exp_q.size() < DEPTH)));
        if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, model_pc);
        chk("if_valid", 32'(bus.if_valid), 32'(exp_q.size() > 0));
        if (bus.if_valid && exp_q.size() > 0) begin
            chk("if_instr", bus.if_instr, exp_q[0].instr);
            chk("if_pc", bus.if_pc, exp_q[0].pc);
        end
        if (bus.if_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
        hs  = bus.imem_req_valid && bus.imem_req_ready;
        pop = bus.if_valid && bus.if_ready && !redir;
        if (pop && exp_q.size() > 0) begin
            deliv_q.push_back(exp_q[0].pc);
            exp_q.delete(0);
        end
        if (rsp) begin
            if (redir || mem_q[0].stale) dropped++;
            else exp_q.push_back('{mem_q[0].addr ^ KEY, mem_q[0].addr});
            mem_q.delete(0);
        end
        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            model_pc = bus.redirect_pc & ~32'h3;
        end
        if (hs) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{model_pc, 1'b0, due});
            accept_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        if (mem_q.size() + exp_q.size() > max_occ) max_occ = mem_q.size() + exp_q.size();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
    endtask

    initial begin
        int d0, acc0, drop0, bad;
        bit found;

        // Streaming from reset with an always-ready memory and decoder.
        do_reset();
        repeat (14) tick();
        chk("t1_first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        chk("t1_ndeliv", 32'(deliv_q.size() >= 3), 32'd1);
        if (deliv_q.size() >= 3) begin
            chk("t1_pc0", deliv_q[0], 32'h0);
            chk("t1_pc1", deliv_q[1], 32'h4);
            chk("t1_pc2", deliv_q[2], 32'h8);
        end

        // Decoder stalled: credit caps traffic, head frozen at pc 0.
        do_reset();
        bus.if_ready = 1'b0;
        repeat (10) tick();
        chk("t2_accepted", 32'(accept_q.size()), 32'd2);
        chk("t2_frozen_pc", bus.if_pc, 32'h0);
        chk("t2_frozen_instr", bus.if_instr, KEY);
        bus.if_ready = 1'b1;
        repeat (12) tick();
        chk("t2_max_occ", 32'(max_occ <= DEPTH), 32'd1);
        chk("t2_ndeliv", 32'(deliv_q.size() >= 3), 32'd1);
        if (deliv_q.size() >= 3) begin
            chk("t2_pc0", deliv_q[0], 32'h0);
            chk("t2_pc1", deliv_q[1], 32'h4);
            chk("t2_pc2", deliv_q[2], 32'h8);
        end

        // Memory stalls with 0x10 pending.
        do_reset();
        for (int i = 0; i < 40 && model_pc != 32'h10; i++) tick();
        chk("t3_reach_0x10", model_pc, 32'h10);
        acc0 = accept_q.size();
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_addr_held", bus.imem_req_addr, 32'h10);
        end
        chk("t3_no_accept", 32'(accept_q.size()), 32'(acc0));
        bus.imem_req_ready = 1'b1;
        repeat (6) tick();
        chk("t3_resume_addr", (accept_q.size() > acc0) ? accept_q[acc0] : 32'hDEAD_BEEF, 32'h10);

        // Redirect with two requests in flight, one response landing that cycle.
        do_reset();
        lat_min = 2;
        lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_q.size() == 2 && mem_q[0].due == cyc && exp_q.size() == 0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t4_setup", 32'(found), 32'd1);
        drop0 = dropped;
        acc0  = accept_q.size();
        d0    = deliv_q.size();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1003;
        tick();
        repeat (12) tick();
        chk("t4_dropped", 32'(dropped - drop0), 32'd2);
        chk("t4_first_req", (accept_q.size() > acc0) ? accept_q[acc0] : 32'hDEAD_BEEF, 32'h1000);
        chk("t4_first_pc", (deliv_q.size() > d0) ? deliv_q[d0] : 32'hDEAD_BEEF, 32'h1000);

        // Back-to-back redirects: only the later stream reaches decode.
        do_reset();
        lat_min = 1;
        lat_max = 3;
        repeat (6) tick();
        d0 = deliv_q.size();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        repeat (20) tick();
        bad = 0;
        for (int i = d0; i < deliv_q.size(); i++) begin
            if (deliv_q[i] < 32'h300 || deliv_q[i] >= 32'h400) bad++;
        end
        chk("t5_stale_entries", 32'(bad), 32'd0);
        chk("t5_first_pc", (deliv_q.size() > d0) ? deliv_q[d0] : 32'hDEAD_BEEF, 32'h300);

        // PC wrap past the top of the address space.
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFA;
        tick();
        repeat (15) tick();
        chk("t6_ndeliv", 32'(deliv_q.size() >= 3), 32'd1);
        if (deliv_q.size() >= 3) begin
            chk("t6_pc0", deliv_q[0], 32'hFFFF_FFF8);
            chk("t6_pc1", deliv_q[1], 32'hFFFF_FFFC);
            chk("t6_wrap", deliv_q[2], 32'h0);
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        bus.if_ready = 1'b0;
        repeat (4) tick();
        chk("t7_pre_if_valid", 32'(bus.if_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t7_async_if_valid", 32'(bus.if_valid), 32'd0);
        chk("t7_async_if_instr", bus.if_instr, INSTR_NOP);
        do_reset();
        repeat (6) tick();
        chk("t7_restart_addr", (accept_q.size() > 0) ? accept_q[0] : 32'hDEAD_BEEF, 32'h0);

        // Randomized traffic with random stalls, latencies and redirects.
        do_reset();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            bus.imem_req_ready = ($urandom_range(3, 0) != 0);
            bus.if_ready       = ($urandom_range(3, 0) != 0);
            if ($urandom_range(24, 0) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom();
            end
            tick();
        end
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b1;
        repeat (30) tick();
        chk("rand_drain_mem", 32'(mem_q.size()), 32'd0);
        chk("rand_drain_buf", 32'(exp_q.size()), 32'd0);
        chk("rand_max_occ", 32'(max_occ <= DEPTH), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
